// File: rtl/m_axi_pkg.sv
// Shared AXI definitions: response codes, burst type, read-master FSM states
// and the response-severity merge used when folding RRESP into a status.
package m_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  // SLVERR and DECERR rank equally; the first error seen is the one kept.
  function automatic logic [1:0] resp_rank(input logic [1:0] resp);
    case (resp)
      RESP_SLVERR, RESP_DECERR: resp_rank = 2'd2;
      RESP_EXOKAY:              resp_rank = 2'd1;
      default:                  resp_rank = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] resp_worse(input logic [1:0] held, input logic [1:0] incoming);
    resp_worse = (resp_rank(incoming) > resp_rank(held)) ? incoming : held;
  endfunction

endpackage

// File: rtl/m_axi_read_master.sv
// Single-outstanding AXI4 INCR read initiator with a one-deep registered user stream.
// Optional RLAST/RID checking is enabled by defining M_AXI_READ_MASTER_PROTO_CHECK_EN.
module m_axi_read_master
  import m_axi_pkg::*;
#(
  parameter int RDATA_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int ID_LENGTH   = 4,
  parameter int ARID_VALUE  = 0
) (
  input  logic                   M_AXI_ACLK,
  input  logic                   M_AXI_ARESET,
  output logic [ADDR_WIDTH-1:0]  M_AXI_ARADDR,
  output logic                   M_AXI_ARVALID,
  input  logic                   M_AXI_ARREADY,
  output logic [7:0]             M_AXI_ARLEN,
  output logic [2:0]             M_AXI_ARSIZE,
  output logic [1:0]             M_AXI_ARBURST,
  output logic [ID_LENGTH-1:0]   M_AXI_ARID,
  input  logic [RDATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic                   M_AXI_RVALID,
  output logic                   M_AXI_RREADY,
  input  logic                   M_AXI_RLAST,
  input  logic [1:0]             M_AXI_RRESP,
  input  logic [ID_LENGTH-1:0]   M_AXI_RID,
  input  logic [ADDR_WIDTH-1:0]  REQ_ADDR,
  input  logic [7:0]             REQ_LEN,
  input  logic                   REQ_VALID,
  output logic                   REQ_READY,
  output logic [RDATA_WIDTH-1:0] DATA_FROM_AXI,
  output logic                   DATA_VALID,
  input  logic                   DATA_READY,
  output logic                   DATA_LAST,
  output logic                   DONE,
  output logic [1:0]             STATUS,
  output logic                   PROTO_ERR
);

  localparam int SIZE = $clog2(RDATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << SIZE;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    araddr_q;
  logic [7:0]               arlen_q;
  logic [7:0]               cnt_q;
  logic                     got_last_q;
  logic [RDATA_WIDTH-1:0]   data_q;
  logic                     dvalid_q;
  logic                     dlast_q;
  logic [1:0]               status_q;
  logic                     req_ready_q;
  logic                     proto_q;
  logic                     req_accept;
  logic                     r_hs;
  logic                     user_hs;
  logic                     beat_is_last;

  assign req_accept   = req_ready_q && REQ_VALID;
  assign user_hs      = dvalid_q && DATA_READY;
  assign beat_is_last = (cnt_q == arlen_q);
  // got_last_q stops RREADY once every beat is in, so stray beats are never absorbed.
  assign M_AXI_RREADY = (state_q == ST_DATA) && !got_last_q && (!dvalid_q || DATA_READY);
  assign r_hs         = M_AXI_RVALID && M_AXI_RREADY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_accept) state_d = ST_ADDR;
      ST_ADDR: if (M_AXI_ARREADY) state_d = ST_DATA;
      ST_DATA: if (user_hs && dlast_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // REQ_READY is registered so it stays low while reset is held.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == ST_IDLE);
    end
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      araddr_q   <= '0;
      arlen_q    <= '0;
      cnt_q      <= '0;
      got_last_q <= 1'b0;
      status_q   <= RESP_OKAY;
      data_q     <= '0;
      dvalid_q   <= 1'b0;
      dlast_q    <= 1'b0;
    end else begin
      if (req_accept) begin
        araddr_q   <= REQ_ADDR & ALIGN_MASK;
        arlen_q    <= REQ_LEN;
        cnt_q      <= '0;
        got_last_q <= 1'b0;
        status_q   <= RESP_OKAY;
      end
      if (r_hs) begin
        data_q     <= M_AXI_RDATA;
        dvalid_q   <= 1'b1;
        dlast_q    <= beat_is_last;
        cnt_q      <= cnt_q + 8'd1;
        got_last_q <= got_last_q | beat_is_last;
        status_q   <= resp_worse(status_q, M_AXI_RRESP);
      end else if (user_hs) begin
        dvalid_q <= 1'b0;
        dlast_q  <= 1'b0;
      end
    end
  end

`ifdef M_AXI_READ_MASTER_PROTO_CHECK_EN
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      proto_q <= 1'b0;
    end else if (req_accept) begin
      proto_q <= 1'b0;
    end else if (r_hs && ((M_AXI_RLAST != beat_is_last) ||
                          (M_AXI_RID != ID_LENGTH'(ARID_VALUE)))) begin
      proto_q <= 1'b1;
    end
  end
`else
  logic unused_proto;
  assign unused_proto = ^{M_AXI_RLAST, M_AXI_RID};
  assign proto_q      = 1'b0;
`endif

  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = arlen_q;
  assign M_AXI_ARVALID = (state_q == ST_ADDR);
  assign M_AXI_ARSIZE  = 3'(SIZE);
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARID    = ID_LENGTH'(ARID_VALUE);
  assign REQ_READY     = req_ready_q;
  assign DATA_FROM_AXI = data_q;
  assign DATA_VALID    = dvalid_q;
  assign DATA_LAST     = dlast_q;
  assign DONE          = user_hs && dlast_q;
  assign STATUS        = status_q;
  assign PROTO_ERR     = proto_q;

endmodule

// File: doc/m_axi_read_master.md
# m_axi_read_master

Single-outstanding AXI4 read initiator; the master counterpart to the team's slave-side conversion blocks. Accepts a user read request (start address, burst length), issues one INCR burst on AR, collects R beats, and presents them on a registered valid/ready user stream with per-transaction status. Sits between user logic and an AXI interconnect or slave port.

## Interface
- RDATA_WIDTH, 32: R data width in bits; power of two, 8..1024.
- ADDR_WIDTH, 8: byte address width.
- ID_LENGTH, 4: AXI ID width.
- ARID_VALUE, 0: constant driven on M_AXI_ARID and expected on M_AXI_RID.
---
- M_AXI_ACLK  in  1  sole clock; all logic on rising edge.
- M_AXI_ARESET  in  1  reset, asynchronous, active-high.
- M_AXI_ARADDR  out  ADDR_WIDTH  burst start address.
- M_AXI_ARVALID  out  1  AR valid.
- M_AXI_ARREADY  in  1  AR ready.
- M_AXI_ARLEN  out  8  beats minus one.
- M_AXI_ARSIZE  out  3  constant clog2(RDATA_WIDTH/8).
- M_AXI_ARBURST  out  2  constant 2'b01 (INCR).
- M_AXI_ARID  out  ID_LENGTH  constant ARID_VALUE.
- M_AXI_RDATA  in  RDATA_WIDTH  read data.
- M_AXI_RVALID  in  1  R valid.
- M_AXI_RREADY  out  1  R ready.
- M_AXI_RLAST  in  1  last beat.
- M_AXI_RRESP  in  2  beat response.
- M_AXI_RID  in  ID_LENGTH  beat ID.
- REQ_ADDR  in  ADDR_WIDTH  user start address.
- REQ_LEN  in  8  user beats minus one.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  request ready.
- DATA_FROM_AXI  out  RDATA_WIDTH  beat data to user.
- DATA_VALID  out  1  beat valid.
- DATA_READY  in  1  user accepts beat.
- DATA_LAST  out  1  marks final beat.
- DONE  out  1  one-cycle pulse at transaction end.
- STATUS  out  2  worst RRESP of last transaction (SLVERR/DECERR > EXOKAY > OKAY).
- PROTO_ERR  out  1  protocol violation flag (see Configuration).

## Operation
- FSM: IDLE, ADDR, DATA.
- IDLE: REQ_READY=1. On REQ_VALID: latch ARADDR={REQ_ADDR[ADDR_WIDTH-1:s], s'b0} with s=ARSIZE value, ARLEN=REQ_LEN; clear beat counter, STATUS, PROTO_ERR; go ADDR.
- ADDR: ARVALID=1; ARADDR/ARLEN stable until ARVALID&&ARREADY; then go DATA. ARVALID never drops without handshake.
- DATA: RREADY = !DATA_VALID || DATA_READY (one-deep output register). On RVALID&&RREADY: register RDATA into DATA_FROM_AXI, set DATA_VALID, DATA_LAST=(counter==ARLEN), counter+1, fold RRESP into STATUS.
- Transaction ends when beat with DATA_LAST is accepted by user (DATA_VALID&&DATA_READY&&DATA_LAST): DONE=1 that cycle, next state IDLE.
- No RRESP causes early termination; all ARLEN+1 beats always collected.
- No 4 KB splitting; caller keeps bursts inside boundary.
- Counter 8 bits; counter==ARLEN compare only, no wrap within legal use.

## Timing
- Reset values: ARVALID=0, RREADY=0, DATA_VALID=0, DATA_LAST=0, DONE=0, REQ_READY=0 in reset, 1 first cycle after, STATUS=0, PROTO_ERR=0, ARADDR=0, ARLEN=0, DATA_FROM_AXI=0.
- Request accept to ARVALID: 1 cycle.
- R handshake to DATA_VALID: 1 cycle; full throughput 1 beat/cycle when DATA_READY held high.
- DONE is combinational on final user handshake; REQ_READY rises next cycle.
- Simultaneous DATA_READY and new R beat: output register replaced same edge, no bubble.
- DATA_READY low: RREADY low next evaluation; no beat lost or duplicated.
- Reset mid-burst: all state cleared asynchronously; system resets slave concurrently.

## Configuration
- M_AXI_READ_MASTER_PROTO_CHECK_EN defined: PROTO_ERR set (sticky to next request) if RLAST != (counter==ARLEN) on any beat, or RID != ARID_VALUE.
- Undefined: RLAST and RID ignored, PROTO_ERR tied 0; termination by counter only.

## Structure
- Shared package m_axi_pkg: RESP codes (OKAY, EXOKAY, SLVERR, DECERR), BURST_INCR, FSM state encoding, resp-severity compare function.
- No sub-module required; output register may be m_axi_skid_reg if reused elsewhere.

## Test plan
- REQ_ADDR=0x10, REQ_LEN=3, slave OKAY, DATA_READY=1 -> ARADDR=0x10, ARLEN=3, 4 beats, DATA_LAST on 4th, DONE once, STATUS=0.
- REQ_LEN=0 -> single beat with DATA_LAST=1, DONE same cycle as accept.
- DATA_READY toggling 1/0 over 8-beat burst -> data order preserved, RREADY low whenever output full and not drained.
- Beat 2 of 4 returns SLVERR -> all 4 beats delivered, STATUS=2'b10.
- With macro: RLAST asserted on beat 2 of 4 -> PROTO_ERR=1; without macro PROTO_ERR=0.
- ARESET asserted during DATA -> all outputs at reset values immediately; next request completes normally.
